// File: rtl/sc_move_pkg.sv
// Shared encodings for the Frogger move controller: FSM states, latched
// direction codes and shift-select values.
package sc_move_pkg;

    typedef enum logic [3:0] {
        RESET = 4'd0,
        START = 4'd1,
        CHECK = 4'd2,
        INIT  = 4'd3,
        UP    = 4'd4,
        DOWN  = 4'd5,
        LEFT  = 4'd6,
        RIGHT = 4'd7,
        HOLD  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    function automatic state_t dirState(input dir_t d);
        case (d)
            DIR_UP:   dirState = UP;
            DIR_DOWN: dirState = DOWN;
            DIR_LEFT: dirState = LEFT;
            default:  dirState = RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/sc_move_repeat_timer.sv
// Loadable down-counter for the hold/auto-repeat delay; sticks at zero.
module sc_move_repeat_timer #(
    parameter int CNT_WIDTH = 26
) (
    input  logic                 clock,
    input  logic                 resetInLow,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] loadValue,
    input  logic                 decrement,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clock or negedge resetInLow) begin
        if (!resetInLow)
            count <= '0;
        else if (load)
            count <= loadValue;
        else if (decrement && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sc_statemachine_move_rpt.sv
// Button-to-strobe controller for the point/frog registers, with edge
// blocking, hold-to-repeat and a saturating up-move score.
module sc_statemachine_move_rpt
    import sc_move_pkg::*;
#(
    parameter int REPEAT_EN     = 1,
    parameter int CNT_WIDTH     = 26,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 12500000,
    parameter int SCORE_WIDTH   = 8
) (
    input  logic                   SC_STATEMACHINE_MOVE_CLOCK_50,
    input  logic                   SC_STATEMACHINE_MOVE_RESET_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_startGame_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_upButton_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_downButton_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_leftButton_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_rightButton_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_topEdge_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_bottomEdge_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_leftEdge_InLow,
    input  logic                   SC_STATEMACHINE_MOVE_rightEdge_InLow,
    output logic                   SC_STATEMACHINE_MOVE_clear_OutLow,
    output logic                   SC_STATEMACHINE_MOVE_load0_OutLow,
    output logic                   SC_STATEMACHINE_MOVE_load1_OutLow,
    output logic [1:0]             SC_STATEMACHINE_MOVE_shiftselection_Out,
    output logic [SCORE_WIDTH-1:0] SC_STATEMACHINE_MOVE_score_Out
);

    localparam logic [CNT_WIDTH-1:0] DELAY_LD  = CNT_WIDTH'(REPEAT_DELAY - 2);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LD = CNT_WIDTH'(REPEAT_PERIOD - 2);

    state_t state, chkAct, actNext;
    dir_t   dir;
    logic   holdStart, rptFlag;
    logic   upReq, downReq, leftReq, rightReq, anyBtn, latchedReq;
    logic   holdActive, fire, isAction;
    logic   tmrLoad, tmrDec, tmrZero;
    logic [CNT_WIDTH-1:0]   tmrLoadVal;
    logic [SCORE_WIDTH-1:0] scoreInc;

    // A blocked direction is indistinguishable from an unpressed one.
    assign upReq    = !SC_STATEMACHINE_MOVE_upButton_InLow    && SC_STATEMACHINE_MOVE_topEdge_InLow;
    assign downReq  = !SC_STATEMACHINE_MOVE_downButton_InLow  && SC_STATEMACHINE_MOVE_bottomEdge_InLow;
    assign leftReq  = !SC_STATEMACHINE_MOVE_leftButton_InLow  && SC_STATEMACHINE_MOVE_leftEdge_InLow;
    assign rightReq = !SC_STATEMACHINE_MOVE_rightButton_InLow && SC_STATEMACHINE_MOVE_rightEdge_InLow;
    assign anyBtn   = !(&{SC_STATEMACHINE_MOVE_startGame_InLow, SC_STATEMACHINE_MOVE_upButton_InLow,
                          SC_STATEMACHINE_MOVE_downButton_InLow, SC_STATEMACHINE_MOVE_leftButton_InLow,
                          SC_STATEMACHINE_MOVE_rightButton_InLow});
    assign scoreInc = (SC_STATEMACHINE_MOVE_score_Out == '1) ? SC_STATEMACHINE_MOVE_score_Out
                                                              : SC_STATEMACHINE_MOVE_score_Out + 1'b1;

    always_comb begin
        chkAct = CHECK;
        if (!SC_STATEMACHINE_MOVE_startGame_InLow) chkAct = INIT;
        else if (upReq)                            chkAct = UP;
        else if (downReq)                          chkAct = DOWN;
        else if (leftReq)                          chkAct = LEFT;
        else if (rightReq)                         chkAct = RIGHT;

        case (dir)
            DIR_UP:   latchedReq = upReq;
            DIR_DOWN: latchedReq = downReq;
            DIR_LEFT: latchedReq = leftReq;
            default:  latchedReq = rightReq;
        endcase

        holdActive = (REPEAT_EN != 0) && anyBtn && !holdStart;
        isAction   = state inside {INIT, UP, DOWN, LEFT, RIGHT};
        fire       = (state == CHECK && chkAct != CHECK) ||
                     (state == HOLD && holdActive && tmrZero && latchedReq);
        actNext    = (state == HOLD) ? dirState(dir) : chkAct;
        // Expiry with the latched direction blocked or released just rearms.
        tmrLoad    = isAction || (state == HOLD && holdActive && tmrZero && !latchedReq);
        tmrLoadVal = (isAction && !rptFlag) ? DELAY_LD : PERIOD_LD;
        tmrDec     = (state == HOLD) && holdActive && !tmrZero;
    end

    sc_move_repeat_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clock      (SC_STATEMACHINE_MOVE_CLOCK_50),
        .resetInLow (SC_STATEMACHINE_MOVE_RESET_InLow),
        .load       (tmrLoad),
        .loadValue  (tmrLoadVal),
        .decrement  (tmrDec),
        .zero       (tmrZero)
    );

    always_ff @(posedge SC_STATEMACHINE_MOVE_CLOCK_50 or negedge SC_STATEMACHINE_MOVE_RESET_InLow) begin
        if (!SC_STATEMACHINE_MOVE_RESET_InLow) begin
            state                                   <= RESET;
            dir                                     <= DIR_UP;
            holdStart                               <= 1'b0;
            rptFlag                                 <= 1'b0;
            SC_STATEMACHINE_MOVE_clear_OutLow       <= 1'b1;
            SC_STATEMACHINE_MOVE_load0_OutLow       <= 1'b1;
            SC_STATEMACHINE_MOVE_load1_OutLow       <= 1'b1;
            SC_STATEMACHINE_MOVE_shiftselection_Out <= SHIFT_HOLD;
            SC_STATEMACHINE_MOVE_score_Out          <= '0;
        end else begin
            SC_STATEMACHINE_MOVE_clear_OutLow       <= 1'b1;
            SC_STATEMACHINE_MOVE_load0_OutLow       <= 1'b1;
            SC_STATEMACHINE_MOVE_load1_OutLow       <= 1'b1;
            SC_STATEMACHINE_MOVE_shiftselection_Out <= SHIFT_HOLD;
            if (fire) begin
                state   <= actNext;
                rptFlag <= (state == HOLD);
                case (actNext)
                    INIT: begin
                        SC_STATEMACHINE_MOVE_clear_OutLow <= 1'b0;
                        SC_STATEMACHINE_MOVE_score_Out    <= '0;
                        holdStart                         <= 1'b1;
                    end
                    UP: begin
                        SC_STATEMACHINE_MOVE_load0_OutLow <= 1'b0;
                        SC_STATEMACHINE_MOVE_score_Out    <= scoreInc;
                        dir                               <= DIR_UP;
                        holdStart                         <= 1'b0;
                    end
                    DOWN: begin
                        SC_STATEMACHINE_MOVE_load1_OutLow <= 1'b0;
                        dir                               <= DIR_DOWN;
                        holdStart                         <= 1'b0;
                    end
                    LEFT: begin
                        SC_STATEMACHINE_MOVE_shiftselection_Out <= SHIFT_LEFT;
                        dir                                     <= DIR_LEFT;
                        holdStart                               <= 1'b0;
                    end
                    default: begin
                        SC_STATEMACHINE_MOVE_shiftselection_Out <= SHIFT_RIGHT;
                        dir                                     <= DIR_RIGHT;
                        holdStart                               <= 1'b0;
                    end
                endcase
            end else begin
                case (state)
                    RESET:                        state <= START;
                    START:                        state <= CHECK;
                    INIT, UP, DOWN, LEFT, RIGHT:  state <= HOLD;
                    HOLD:                         if (!anyBtn) state <= CHECK;
                    default:                      state <= CHECK;
                endcase
            end
        end
    end

endmodule
